// File: rtl/rm_ihpsg13_1p_256x48_c2_bm_bist.sv
// Behavioural model of a 256x48 single-port SRAM macro with a per-bit write mask,
// plus a BIST port that takes over the array through a combinational control mux.
module rm_ihpsg13_1p_256x48_c2_bm_bist (
    input  logic        A_CLK,
    input  logic        A_RST_N,
    input  logic        A_MEN,
    input  logic        A_WEN,
    input  logic        A_REN,
    input  logic [7:0]  A_ADDR,
    input  logic [47:0] A_DIN,
    input  logic [47:0] A_BM,
    input  logic        A_DLY,
    output logic [47:0] A_DOUT,
    input  logic        A_BIST_CLK,
    input  logic        A_BIST_EN,
    input  logic        A_BIST_MEN,
    input  logic        A_BIST_WEN,
    input  logic        A_BIST_REN,
    input  logic [7:0]  A_BIST_ADDR,
    input  logic [47:0] A_BIST_DIN,
    input  logic [47:0] A_BIST_BM
);

    localparam int ADDR_W = 8;
    localparam int DATA_W = 48;
    localparam int DEPTH  = 256;

    logic              men;
    logic              wen;
    logic              ren;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] bm;
    logic              wr_en;
    logic              rd_en;

    // Timing-tuning and BIST clock pins exist only for macro pin compatibility.
    logic unused_pins;
    assign unused_pins = A_DLY ^ A_BIST_CLK;

    // NOTE: every signal written here is assigned on every path, so no latch is inferred.
    always_comb begin
        if (A_BIST_EN) begin
            men  = A_BIST_MEN;
            wen  = A_BIST_WEN;
            ren  = A_BIST_REN;
            addr = A_BIST_ADDR;
            din  = A_BIST_DIN;
            bm   = A_BIST_BM;
        end else begin
            men  = A_MEN;
            wen  = A_WEN;
            ren  = A_REN;
            addr = A_ADDR;
            din  = A_DIN;
            bm   = A_BM;
        end
    end

    // Reset low at an edge aborts the access; a write wins over a simultaneous read.
    assign wr_en = A_RST_N & men & wen;
    assign rd_en = men & ren & ~wen;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array is deliberately not reset, so contents survive A_RST_N pulses.
    always_ff @(posedge A_CLK) begin
        if (wr_en) begin
            mem[addr] <= (mem[addr] & ~bm) | (din & bm);
        end
    end

    // NOTE: non-blocking assignments keep read-during-write ordering race-free.
    always_ff @(posedge A_CLK or negedge A_RST_N) begin
        if (!A_RST_N) begin
            A_DOUT <= '0;
        end else if (rd_en) begin
            A_DOUT <= mem[addr];
        end
    end

endmodule

// File: tb/tb_rm_ihpsg13_1p_256x48_c2_bm_bist.sv
// Directed plus randomized bench; a per-word value/known-bits model predicts A_DOUT.
module tb_rm_ihpsg13_1p_256x48_c2_bm_bist;

    logic        A_CLK = 1'b0;
    logic        A_RST_N = 1'b0;
    logic        A_MEN = 1'b0;
    logic        A_WEN = 1'b0;
    logic        A_REN = 1'b0;
    logic [7:0]  A_ADDR = '0;
    logic [47:0] A_DIN = '0;
    logic [47:0] A_BM = '0;
    logic        A_DLY = 1'b0;
    logic [47:0] A_DOUT;
    logic        A_BIST_CLK = 1'b0;
    logic        A_BIST_EN = 1'b0;
    logic        A_BIST_MEN = 1'b0;
    logic        A_BIST_WEN = 1'b0;
    logic        A_BIST_REN = 1'b0;
    logic [7:0]  A_BIST_ADDR = '0;
    logic [47:0] A_BIST_DIN = '0;
    logic [47:0] A_BIST_BM = '0;

    rm_ihpsg13_1p_256x48_c2_bm_bist dut (
        .A_CLK       (A_CLK),
        .A_RST_N     (A_RST_N),
        .A_MEN       (A_MEN),
        .A_WEN       (A_WEN),
        .A_REN       (A_REN),
        .A_ADDR      (A_ADDR),
        .A_DIN       (A_DIN),
        .A_BM        (A_BM),
        .A_DLY       (A_DLY),
        .A_DOUT      (A_DOUT),
        .A_BIST_CLK  (A_BIST_CLK),
        .A_BIST_EN   (A_BIST_EN),
        .A_BIST_MEN  (A_BIST_MEN),
        .A_BIST_WEN  (A_BIST_WEN),
        .A_BIST_REN  (A_BIST_REN),
        .A_BIST_ADDR (A_BIST_ADDR),
        .A_BIST_DIN  (A_BIST_DIN),
        .A_BIST_BM   (A_BIST_BM)
    );

    always #5 A_CLK = ~A_CLK;
    always #7 A_BIST_CLK = ~A_BIST_CLK;

    localparam logic [47:0] ALL1 = 48'hFFFF_FFFF_FFFF;

    // Model: stored value plus which bits have ever been written (others are undefined).
    logic [47:0] model_mem   [256];
    logic [47:0] model_known [256];
    logic [47:0] exp_dout  = '0;
    logic [47:0] exp_known = ALL1;
    bit          other_hit = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [47:0] obs,
                         input logic [47:0] exp, input logic [47:0] care);
        checks++;
        assert ((obs & care) === (exp & care)) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (care %h)", tag, obs, exp, care);
        end
    endtask

    function automatic logic [47:0] rnd48();
        return {$urandom(), $urandom()};
    endfunction

    // One clocked access on the selected port; the other port carries junk.
    task automatic do_op(input bit bist, input bit men, input bit wen, input bit ren,
                         input logic [7:0] addr, input logic [47:0] din,
                         input logic [47:0] bm, input string tag);
        logic        o_men, o_wen, o_ren;
        logic [7:0]  o_addr;
        logic [47:0] o_din, o_bm;
        o_men  = 1'($urandom());
        o_wen  = 1'($urandom());
        o_ren  = 1'($urandom());
        o_addr = 8'($urandom());
        o_din  = rnd48();
        o_bm   = rnd48();
        if (other_hit) begin
            o_men = 1'b1; o_wen = 1'b1; o_ren = 1'b0;
            o_addr = addr; o_din = ~din; o_bm = ALL1;
        end
        A_BIST_EN = bist;
        A_DLY     = 1'($urandom());
        if (bist) begin
            {A_BIST_MEN, A_BIST_WEN, A_BIST_REN} = {men, wen, ren};
            A_BIST_ADDR = addr; A_BIST_DIN = din; A_BIST_BM = bm;
            {A_MEN, A_WEN, A_REN} = {o_men, o_wen, o_ren};
            A_ADDR = o_addr; A_DIN = o_din; A_BM = o_bm;
        end else begin
            {A_MEN, A_WEN, A_REN} = {men, wen, ren};
            A_ADDR = addr; A_DIN = din; A_BM = bm;
            {A_BIST_MEN, A_BIST_WEN, A_BIST_REN} = {o_men, o_wen, o_ren};
            A_BIST_ADDR = o_addr; A_BIST_DIN = o_din; A_BIST_BM = o_bm;
        end
        @(posedge A_CLK);
        #1;
        if (men && wen) begin
            for (int i = 0; i < 48; i++) begin
                if (bm[i]) begin
                    model_mem[addr][i]   = din[i];
                    model_known[addr][i] = 1'b1;
                end
            end
        end else if (men && ren) begin
            exp_dout  = model_mem[addr];
            exp_known = model_known[addr];
        end
        check(tag, A_DOUT, exp_dout, exp_known);
    endtask

    task automatic idle_inputs();
        {A_MEN, A_WEN, A_REN} = 3'b000;
        {A_BIST_MEN, A_BIST_WEN, A_BIST_REN} = 3'b000;
        A_BIST_EN = 1'b0;
    endtask

    // Reset pulse starting mid-cycle, with an attempted write to abort_addr while held.
    task automatic reset_pulse(input logic [7:0] abort_addr);
        idle_inputs();
        #2 A_RST_N = 1'b0;
        #1;
        exp_dout  = '0;
        exp_known = ALL1;
        check("reset_async_clear", A_DOUT, exp_dout, exp_known);
        {A_MEN, A_WEN, A_REN} = 3'b111;
        A_ADDR = abort_addr;
        A_DIN  = rnd48();
        A_BM   = ALL1;
        @(posedge A_CLK);
        #1;
        check("reset_hold", A_DOUT, exp_dout, exp_known);
        idle_inputs();
        #2 A_RST_N = 1'b1;
        @(posedge A_CLK);
        #1;
        check("reset_release_idle", A_DOUT, exp_dout, exp_known);
    endtask

    initial begin
        logic [7:0]  r_addr;
        logic [47:0] r_bm;
        int          sel;

        for (int i = 0; i < 256; i++) begin
            model_mem[i]   = '0;
            model_known[i] = '0;
        end

        // Reset then idle
        repeat (3) @(posedge A_CLK);
        #1;
        check("in_reset", A_DOUT, 48'h0, ALL1);
        #2 A_RST_N = 1'b1;
        @(posedge A_CLK);
        #1;
        do_op(0, 0, 0, 0, 8'h00, '0, '0, "reset_idle");

        // Full-mask write then read
        do_op(0, 1, 1, 0, 8'h05, 48'h123456789ABC, ALL1, "wr05");
        do_op(0, 1, 0, 1, 8'h05, '0, '0, "rd05");
        check("rd05_const", A_DOUT, 48'h123456789ABC, ALL1);

        // Partial-mask write
        do_op(0, 1, 1, 0, 8'hFF, ALL1, ALL1, "wrFF_all");
        do_op(0, 1, 1, 0, 8'hFF, 48'h0, 48'h00000000FFFF, "wrFF_part");
        do_op(0, 1, 0, 1, 8'hFF, '0, '0, "rdFF");
        check("rdFF_const", A_DOUT, 48'hFFFFFFFF0000, ALL1);

        // Zero mask leaves word intact; write+read together writes only
        do_op(0, 1, 1, 0, 8'hFF, 48'h0, 48'h0, "wrFF_bm0");
        do_op(0, 1, 1, 1, 8'h05, 48'h0, 48'h0000000000FF, "wr_rd_same");
        check("wr_rd_hold", A_DOUT, 48'hFFFFFFFF0000, ALL1);
        do_op(0, 1, 0, 1, 8'hFF, '0, '0, "rdFF_again");

        // Enable gating
        do_op(0, 0, 1, 1, 8'h05, 48'hDEADBEEF0000, ALL1, "men0_wr");
        do_op(0, 1, 0, 1, 8'h05, '0, '0, "rd05_old");
        check("rd05_old_const", A_DOUT, 48'h123456789A00, ALL1);
        for (int i = 0; i < 3; i++) do_op(0, 1, 0, 0, 8'h05, rnd48(), ALL1, "ren0_hold");

        // BIST path wins while functional port writes elsewhere-data to same word
        other_hit = 1'b1;
        do_op(1, 1, 1, 0, 8'h00, 48'hA5A5A5A5A5A5, ALL1, "bist_wr00");
        other_hit = 1'b0;
        do_op(0, 1, 0, 1, 8'h00, '0, '0, "rd00");
        check("rd00_const", A_DOUT, 48'hA5A5A5A5A5A5, ALL1);

        // Reset keeps the array and aborts an access held during reset
        do_op(0, 1, 1, 0, 8'h10, 48'h1, ALL1, "wr10");
        do_op(0, 1, 0, 1, 8'h10, '0, '0, "rd10_pre");
        reset_pulse(8'h10);
        do_op(0, 1, 0, 1, 8'h10, '0, '0, "rd10_post");
        check("rd10_const", A_DOUT, 48'h1, ALL1);

        // Randomized traffic on both ports
        for (int n = 0; n < 600; n++) begin
            r_addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom());
            sel = $urandom_range(0, 2);
            r_bm = (sel == 0) ? ALL1 : (sel == 1) ? 48'h0 : rnd48();
            if (n == 300) reset_pulse(r_addr);
            do_op(1'($urandom()), $urandom_range(0, 3) != 0, 1'($urandom()),
                  1'($urandom()), r_addr, rnd48(), r_bm, "random");
        end

        // Readback sweep of the whole array
        for (int a = 0; a < 256; a++) do_op(1'($urandom()), 1, 0, 1, 8'(a), '0, '0, "sweep");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
